router_pkt_fsm: RTL and testbench
=================================

Name: router_pkt_fsm

Overview:
- Packet-receive controller for the 1x3 router.
- Sequences the input register block and router_sync through header decode, payload load, FIFO-full stall, parity load and parity check.
- Drives detect_add and write_enb_reg into router_sync, and the load/strobe controls into the register block.
- Asserts busy toward the source so it holds pkt_valid/data while the router cannot accept bytes.

Parameters:
- ADDR_W, 2, width of the destination address field (data_in[1:0] of the header).
- WAIT_TIMEOUT, 30, cycle limit in WAIT_TILL_EMPTY; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  source byte valid; deassertion marks that the next byte is parity.
- data_in  in  ADDR_W  header address bits; sampled only in DECODE_ADDRESS.
- fifo_full  in  1  full flag of the addressed FIFO, muxed by router_sync.
- fifo_empty_0/1/2  in  1 each  empty flags of FIFOs 0..2.
- soft_reset_0/1/2  in  1 each  per-port soft reset from router_sync.
- parity_done  in  1  register block has written the parity byte.
- low_pkt_valid  in  1  register block saw pkt_valid drop during a full stall.
- detect_add  out  1  header decode strobe to router_sync.
- lfd_state  out  1  load-first-data (header) strobe.
- ld_state  out  1  load-payload strobe.
- laf_state  out  1  load-after-full strobe.
- full_state  out  1  FIFO-full stall indicator.
- write_enb_reg  out  1  FIFO write request to router_sync.
- rst_int_reg  out  1  clear internal parity registers.
- busy  out  1  source must hold its data.
- pkt_drop  out  1  one-cycle pulse on timeout abort (feature only; tied 0 otherwise).

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- State is a register. All outputs are a pure combinational decode of the state register (Moore), so they change only after a clock edge.
- Reset (resetn=0, async): state=DECODE_ADDRESS, addr_q=0. Outputs: detect_add=1, all others 0.
- addr_q latches data_in in DECODE_ADDRESS when pkt_valid=1 and data_in!=2'b11. It selects fifo_empty_N and soft_reset_N.
- DECODE_ADDRESS transitions:
  - pkt_valid & valid addr & fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid & valid addr & !empty -> WAIT_TILL_EMPTY.
  - Otherwise stay. Address 2'b11 is ignored; stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full has priority.
- FIFO_FULL_STATE: stay while fifo_full; else -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA. parity_done has priority.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
- Soft reset: soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next edge. This has priority over every other transition. Soft resets of non-addressed ports are ignored.
- Output decode:
  - detect_add = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - laf_state = LOAD_AFTER_FULL.
  - full_state = FIFO_FULL_STATE.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - busy = every state except DECODE_ADDRESS and LOAD_DATA.
- Latency: header accepted into an empty FIFO gives lfd_state on the cycle after the pkt_valid edge and ld_state one cycle later.

Optional Feature:
- Macro: ROUTER_FSM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(WAIT_TIMEOUT+1) runs while in WAIT_TILL_EMPTY and clears on exit.
  - When it reaches WAIT_TIMEOUT-1 with the FIFO still not empty: next state is DECODE_ADDRESS, and pkt_drop pulses 1 cycle. The source is expected to discard the packet.
  - Soft reset keeps priority over the timeout.
- Undefined: no counter; pkt_drop tied 0; WAIT_TILL_EMPTY waits indefinitely.

Decomposition:
- Package router_pkg:
  - state enum/localparams (3-bit encoding, DECODE_ADDRESS=3'd0);
  - ADDR_INVALID=2'b11;
  - NUM_PORTS=3.
- No sub-module: a single always_ff for state/addr_q/counter, an always_comb for next-state and output decode.

Test Plan:
- Reset: resetn=0 mid-LOAD_DATA -> state DECODE_ADDRESS immediately; detect_add=1, write_enb_reg=0, busy=0.
- Normal packet to port 1, empties=111, pkt_valid high 4 cycles then low -> sequence DECODE, LFD, LD x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; rst_int_reg=1 for exactly 1 cycle.
- fifo_full=1 for 3 cycles during LOAD_DATA -> full_state=1 for 3 cycles, busy=1, write_enb_reg=0. Then LOAD_AFTER_FULL with parity_done=0, low_pkt_valid=0 -> LOAD_DATA.
- Header addr 2 with fifo_empty_2=0 -> WAIT_TILL_EMPTY, busy=1. fifo_empty_2 rises -> lfd_state next cycle.
- Addr 2'b11 with pkt_valid=1 -> remains DECODE_ADDRESS, addr_q unchanged.
- soft_reset_0 while addr_q=0 in WAIT_TILL_EMPTY -> DECODE next edge. soft_reset_1 in the same situation -> no effect. With ROUTER_FSM_TIMEOUT_EN: FIFO never empties -> pkt_drop pulse after 30 cycles.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet-receive controller.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         NUM_PORTS    = 3;

endpackage

// File: rtl/router_pkt_fsm.sv
// Packet-receive controller for the 1x3 router (Moore FSM).
// Optional WAIT_TILL_EMPTY timeout with pkt_drop pulse: define ROUTER_FSM_TIMEOUT_EN.
module router_pkt_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              pkt_drop
);

    if (WAIT_TIMEOUT < 2) begin : g_bad_timeout
        $error("WAIT_TIMEOUT must be at least 2");
    end

    state_t                   state_q;
    state_t                   state_d;
    logic [ADDR_W-1:0]        addr_q;
    logic [(1<<ADDR_W)-1:0]   empty_vec;
    logic [(1<<ADDR_W)-1:0]   srst_vec;
    logic                     hdr_ok;

`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             drop_q;

    assign pkt_drop = drop_q;
`else
    assign pkt_drop = 1'b0;
`endif

    // Per-port flags widened to the full address space so the reserved address reads 0.
    always_comb begin
        empty_vec                = '0;
        srst_vec                 = '0;
        empty_vec[NUM_PORTS-1:0] = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        srst_vec[NUM_PORTS-1:0]  = {soft_reset_2, soft_reset_1, soft_reset_0};
    end

    assign hdr_ok = pkt_valid && (data_in != ADDR_W'(ADDR_INVALID));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
`ifdef ROUTER_FSM_TIMEOUT_EN
            wait_cnt <= '0;
            drop_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && hdr_ok) begin
                addr_q <= data_in;
            end
`ifdef ROUTER_FSM_TIMEOUT_EN
            wait_cnt <= (state_q == WAIT_TILL_EMPTY && state_d == WAIT_TILL_EMPTY)
                        ? wait_cnt + 1'b1 : '0;
            drop_q   <= timeout_hit;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
`ifdef ROUTER_FSM_TIMEOUT_EN
        timeout_hit   = 1'b0;
`endif
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    state_d = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_vec[addr_q]) begin
                    state_d = LOAD_FIRST_DATA;
                end
`ifdef ROUTER_FSM_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
                    state_d     = DECODE_ADDRESS;
                    timeout_hit = 1'b1;
                end
`endif
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A soft reset of the addressed port overrides everything, including the timeout.
        if (state_q != DECODE_ADDRESS && srst_vec[addr_q]) begin
            state_d = DECODE_ADDRESS;
`ifdef ROUTER_FSM_TIMEOUT_EN
            timeout_hit = 1'b0;
`endif
        end

        detect_add    = (state_q == DECODE_ADDRESS);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        ld_state      = (state_q == LOAD_DATA);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        full_state    = (state_q == FIFO_FULL_STATE);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                     || (state_q == LOAD_AFTER_FULL);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
    end

endmodule

// File: tb/tb_router_pkt_fsm.sv
// Directed self-checking bench for router_pkt_fsm; output vectors are hand-derived per state.
module tb_router_pkt_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy, pkt_drop;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

    // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}
    localparam logic [7:0] S_DEC  = 8'b1000_0000;
    localparam logic [7:0] S_LFD  = 8'b0100_0001;
    localparam logic [7:0] S_LD   = 8'b0010_0100;
    localparam logic [7:0] S_LAF  = 8'b0001_0101;
    localparam logic [7:0] S_FULL = 8'b0000_1001;
    localparam logic [7:0] S_LP   = 8'b0000_0101;
    localparam logic [7:0] S_CPE  = 8'b0000_0011;
    localparam logic [7:0] S_WAIT = 8'b0000_0001;

    router_pkt_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .pkt_drop      (pkt_drop)
    );

    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, rst_int_reg, busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling edge; the caller waits one negedge and then samples.
    task automatic applyStimulus(input logic pv, input logic [1:0] din, input logic full,
                                 input logic [2:0] emp, input logic [2:0] srst,
                                 input logic pd, input logic lpv);
        pkt_valid     = pv;
        data_in       = din;
        fifo_full     = full;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
        {soft_reset_2, soft_reset_1, soft_reset_0} = srst;
        parity_done   = pd;
        low_pkt_valid = lpv;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        total++;
        if (obs !== S_DEC) begin
            bad++;
            $display("[TB] FAIL reset_outputs got %b want %b", obs, S_DEC);
        end
        total++;
        if (pkt_drop !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_pkt_drop got %b want 0", pkt_drop);
        end
        resetn = 1'b1;
        @(negedge clock);
        total++;
        if (obs !== S_DEC) begin
            bad++;
            $display("[TB] FAIL reset_idle got %b want %b", obs, S_DEC);
        end
    endtask

    task automatic test_normal_packet;
        logic       pv_seq  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_seq [7] = '{S_LFD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DEC};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(pv_seq[i], 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
            @(negedge clock);
            total++;
            if (obs !== exp_seq[i]) begin
                bad++;
                $display("[TB] FAIL normal_packet step %0d got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_full_stall;
        logic       pv_seq   [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       full_seq [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_seq  [10] = '{S_LFD, S_LD, S_FULL, S_FULL, S_FULL, S_LAF, S_LD,
                                      S_LP, S_CPE, S_DEC};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(pv_seq[i], 2'd0, full_seq[i], 3'b111, 3'b000, 1'b0, 1'b0);
            @(negedge clock);
            total++;
            if (obs !== exp_seq[i]) begin
                bad++;
                $display("[TB] FAIL full_stall step %0d got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_laf_branches;
        logic       pv_seq   [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       full_seq [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       pd_seq   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       lpv_seq  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp_seq  [10] = '{S_LFD, S_LD, S_FULL, S_LAF, S_LP, S_CPE, S_FULL,
                                      S_LAF, S_DEC, S_DEC};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(pv_seq[i], 2'd1, full_seq[i], 3'b111, 3'b000, pd_seq[i], lpv_seq[i]);
            @(negedge clock);
            total++;
            if (obs !== exp_seq[i]) begin
                bad++;
                $display("[TB] FAIL laf_branches step %0d got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wait_then_load;
        logic       pv_seq  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] emp_seq [8] = '{3'b011, 3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        logic [7:0] exp_seq [8] = '{S_WAIT, S_WAIT, S_WAIT, S_LFD, S_LD, S_LP, S_CPE, S_DEC};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pv_seq[i], 2'd2, 1'b0, emp_seq[i], 3'b000, 1'b0, 1'b0);
            @(negedge clock);
            total++;
            if (obs !== exp_seq[i]) begin
                bad++;
                $display("[TB] FAIL wait_then_load step %0d got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_invalid_addr;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
            @(negedge clock);
            total++;
            if (obs !== S_DEC) begin
                bad++;
                $display("[TB] FAIL invalid_addr step %0d got %b want %b", i, obs, S_DEC);
            end
        end
        total++;
        if (dut.addr_q !== 2'd2) begin
            bad++;
            $display("[TB] FAIL invalid_addr_hold got %0d want 2", dut.addr_q);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_soft_reset;
        logic       pv_seq   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] emp_seq  [6] = '{3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111};
        logic [2:0] srst_seq [6] = '{3'b000, 3'b010, 3'b001, 3'b001, 3'b001, 3'b000};
        logic [7:0] exp_seq  [6] = '{S_WAIT, S_WAIT, S_DEC, S_LFD, S_DEC, S_DEC};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(pv_seq[i], 2'd0, 1'b0, emp_seq[i], srst_seq[i], 1'b0, 1'b0);
            @(negedge clock);
            total++;
            if (obs !== exp_seq[i]) begin
                bad++;
                $display("[TB] FAIL soft_reset step %0d got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wait_limit;
        int n;
        applyStimulus(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
        @(negedge clock);
        total++;
        if (obs !== S_WAIT) begin
            bad++;
            $display("[TB] FAIL wait_entry got %b want %b", obs, S_WAIT);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
`ifdef ROUTER_FSM_TIMEOUT_EN
        n = 0;
        while (obs === S_WAIT && n < 100) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n !== 30) begin
            bad++;
            $display("[TB] FAIL timeout_cycles got %0d want 30", n);
        end
        total++;
        if (obs !== S_DEC || pkt_drop !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_drop got %b/%b want %b/1", obs, pkt_drop, S_DEC);
        end
        @(negedge clock);
        total++;
        if (pkt_drop !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_pulse_len got %b want 0", pkt_drop);
        end
`else
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (obs !== S_WAIT || pkt_drop !== 1'b0) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("[TB] FAIL wait_forever got %0d bad cycles want 0", n);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b110, 3'b001, 1'b0, 1'b0);
        @(negedge clock);
        total++;
        if (obs !== S_DEC) begin
            bad++;
            $display("[TB] FAIL wait_exit got %b want %b", obs, S_DEC);
        end
`endif
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_reset_mid_packet;
        applyStimulus(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        total++;
        if (obs !== S_LD) begin
            bad++;
            $display("[TB] FAIL mid_reset_setup got %b want %b", obs, S_LD);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (obs !== S_DEC) begin
            bad++;
            $display("[TB] FAIL async_reset got %b want %b", obs, S_DEC);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        total++;
        if (obs !== S_DEC) begin
            bad++;
            $display("[TB] FAIL post_reset got %b want %b", obs, S_DEC);
        end
    endtask

    initial begin
        $display("[TB] starting router_pkt_fsm bench");
        test_reset();
        test_normal_packet();
        test_full_stall();
        test_laf_branches();
        test_wait_then_load();
        test_invalid_addr();
        test_soft_reset();
        test_wait_limit();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
